md4_msg_padder: RTL and testbench
=================================

// Module: md4_msg_padder
// PURPOSE
//  Byte-stream front end of the MD4 datapath. Accepts message bytes over a valid/ready
//  handshake, applies MD4 padding (0x80, zero fill, 64-bit little-endian bit length), and
//  emits 512-bit blocks in the M word layout used by stage1/stage2/stage3 and assemble.
//  Word j is M[32j+31:32j]; message byte i of a block sits in M[8i+7:8i].
// PARAMETERS
//  LEN_W  64  width of the bit-length counter; wraps mod 2^LEN_W; zero-extended into bytes 56..63
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    input beat valid
//  in_ready   out  1    padder can accept a beat
//  in_data    in   8    message byte
//  in_last    in   1    beat ends the message
//  in_empty   in   1    beat carries no byte (legal only with in_last; ends message, zero-length or not)
//  out_valid  out  1    out_block valid
//  out_ready  in   1    downstream accepts block
//  out_block  out  512  padded block, M layout
//  out_first  out  1    block is first of its message (downstream loads IV)
//  out_last   out  1    block is final of its message (downstream runs assemble)
// BEHAVIOUR
//  Reset (async assert, sync release): state=FILL, q=0, len=0, pend_pad=pend_len=0,
//   first=1, buffer=0. Outputs: out_valid=0, out_block=0, out_first=0, out_last=0, in_ready=0 while rst_n=0.
//  q = byte index 0..64 in current block; len = accumulated message bits.
//  in_ready = (state==FILL). Beat is taken when in_valid&in_ready.
//  FILL: data beat -> buf[q]<=in_data, q<=q+1, len<=len+8.
//   If q+1==64 -> EMIT (final=0), pend_pad<=in_last.
//   Else if in_last -> PAD. in_empty beat: no write, no len change, -> PAD.
//  PAD (1 cycle, no input): buf[q]<=8'h80, bytes q+1..63<=0.
//   If q<=55: bytes 56..63<=len -> EMIT final=1. Else -> EMIT final=0, pend_len<=1.
//  LEN (1 cycle): bytes 0..55<=0, bytes 56..63<=len -> EMIT final=1.
//  EMIT: out_valid=1; out_block/out_first/out_last held stable until out_ready.
//   out_last=final; out_first=first. On handshake: first<=0, q<=0, then:
//   final -> FILL, len<=0, first<=1; pend_pad -> PAD (q=0), clear pend_pad;
//   pend_len -> LEN, clear pend_len; else -> FILL.
//  Latency: last beat -> out_valid 2 cycles after the accepting edge (PAD, then EMIT).
//   Full non-final block -> out_valid the cycle after the 64th byte.
//  Throughput: one byte/cycle in FILL; no input is taken in PAD, LEN or EMIT.
//  Boundaries: message length 55 B -> 1 block; 56..63 B or 64 B -> 2 blocks; n*64 B -> n+1 blocks.
//  in_valid is ignored unless in FILL; in_empty without in_last is ignored (no state change).
//  Reset mid-message or mid-EMIT: the partial block is discarded; the next beat starts a new message with first=1.
//  len wraps silently past 2^LEN_W-1.
// TESTING
//  Empty: one beat in_last=1,in_empty=1 -> 1 block, M[31:0]=32'h00000080, rest 0, first=last=1.
//  "abc" (61,62,63 last) -> M[31:0]=32'h80636261, M[479:448]=32'h18, others 0, first=last=1.
//  56 bytes 0x00..0x37 -> blk1 byte56=0x80, bytes57..63=0, first=1,last=0; blk2 all 0 except M[479:448]=32'h1C0, first=0,last=1.
//  64 bytes -> blk1 pure data, last=0; blk2 M[7:0]=8'h80, M[479:448]=32'h200, last=1.
//  Backpressure: out_ready=0 for 10 cycles in EMIT -> out_block stable, in_ready=0, no byte lost; 200-byte random stream matches golden model.
//  Async reset after 30 bytes -> outputs 0 immediately; then "abc" produces exactly the "abc" block with first=1.

Source files
------------

// File: rtl/md4_msg_padder_if.sv
// Byte-in / block-out handshake bundle for the MD4 message padder.
// master = byte producer and block consumer; slave = padder.
interface md4_msg_padder_if;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_empty;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_block;
    logic         out_first;
    logic         out_last;

    modport master (
        output in_valid, in_data, in_last, in_empty, out_ready,
        input  in_ready, out_valid, out_block, out_first, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_empty, out_ready,
        output in_ready, out_valid, out_block, out_first, out_last
    );
endinterface

// File: rtl/md4_msg_padder.sv
// MD4 byte-stream padder: gathers message bytes, appends 0x80 / zero fill / 64-bit LE bit length,
// and hands out 512-bit blocks in M layout (message byte i of a block at M[8i+7:8i]).
module md4_msg_padder #(
    parameter int unsigned LEN_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    md4_msg_padder_if.slave    bus
);
    localparam int unsigned BLK_BYTES = 64;
    localparam int unsigned BLK_W     = 512;
    localparam int unsigned Q_W       = 7;
    localparam int unsigned LEN_POS   = 56;
    localparam int unsigned LEN_BITS  = 64;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        LEN  = 2'd2,
        EMIT = 2'd3
    } state_t;

    state_t             state_q, state_n;
    logic [Q_W-1:0]     q_q, q_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic               pend_pad_q, pend_pad_n;
    logic               pend_len_q, pend_len_n;
    logic               first_q, first_n;
    logic               final_q, final_n;
    logic [BLK_W-1:0]   buf_q, buf_n;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               out_first_q;
    logic               out_last_q;

    logic               take;
    logic [LEN_BITS-1:0] len_ext;

    assign take    = bus.in_valid && in_ready_q;
    assign len_ext = LEN_BITS'(len_q);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            q_q         <= '0;
            len_q       <= '0;
            pend_pad_q  <= 1'b0;
            pend_len_q  <= 1'b0;
            first_q     <= 1'b1;
            final_q     <= 1'b0;
            buf_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_n;
            q_q         <= q_n;
            len_q       <= len_n;
            pend_pad_q  <= pend_pad_n;
            pend_len_q  <= pend_len_n;
            first_q     <= first_n;
            final_q     <= final_n;
            buf_q       <= buf_n;
            in_ready_q  <= (state_n == FILL);
            out_valid_q <= (state_n == EMIT);
            out_first_q <= (state_n == EMIT) && first_n;
            out_last_q  <= (state_n == EMIT) && final_n;
        end
    end

    // Next-state and buffer update
    always_comb begin
        state_n    = state_q;
        q_n        = q_q;
        len_n      = len_q;
        pend_pad_n = pend_pad_q;
        pend_len_n = pend_len_q;
        first_n    = first_q;
        final_n    = final_q;
        buf_n      = buf_q;

        case (state_q)
            FILL: begin
                if (take) begin
                    if (bus.in_empty) begin
                        // empty beat only matters when it terminates the message
                        if (bus.in_last) begin
                            state_n = PAD;
                        end
                    end else begin
                        buf_n[{q_q[5:0], 3'b000} +: 8] = bus.in_data;
                        q_n   = q_q + Q_W'(1);
                        len_n = len_q + LEN_W'(8);
                        if (q_q == Q_W'(BLK_BYTES - 1)) begin
                            state_n    = EMIT;
                            final_n    = 1'b0;
                            pend_pad_n = bus.in_last;
                        end else if (bus.in_last) begin
                            state_n = PAD;
                        end
                    end
                end
            end

            PAD: begin
                for (int unsigned i = 0; i < BLK_BYTES; i++) begin
                    if (Q_W'(i) == q_q) begin
                        buf_n[8*i +: 8] = 8'h80;
                    end else if (Q_W'(i) > q_q) begin
                        buf_n[8*i +: 8] = 8'h00;
                    end
                end
                state_n = EMIT;
                // length fits behind the marker only if the marker lands in bytes 0..55
                if (q_q <= Q_W'(LEN_POS - 1)) begin
                    buf_n[BLK_W-1 -: LEN_BITS] = len_ext;
                    final_n = 1'b1;
                end else begin
                    final_n    = 1'b0;
                    pend_len_n = 1'b1;
                end
            end

            LEN: begin
                buf_n   = {len_ext, (BLK_W - LEN_BITS)'(0)};
                state_n = EMIT;
                final_n = 1'b1;
            end

            EMIT: begin
                if (bus.out_ready) begin
                    first_n = 1'b0;
                    q_n     = '0;
                    if (final_q) begin
                        state_n = FILL;
                        len_n   = '0;
                        first_n = 1'b1;
                    end else if (pend_pad_q) begin
                        state_n    = PAD;
                        pend_pad_n = 1'b0;
                    end else if (pend_len_q) begin
                        state_n    = LEN;
                        pend_len_n = 1'b0;
                    end else begin
                        state_n = FILL;
                    end
                end
            end

            default: begin
                state_n = FILL;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_block = buf_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_md4_msg_padder.sv
// Directed bench for md4_msg_padder: hand-built padded blocks, latency, backpressure,
// a reference padding model for random messages, and mid-message reset.
module tb_md4_msg_padder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    md4_msg_padder_if bus();

    md4_msg_padder #(.LEN_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [511:0] got_blk[$];
    logic         got_first[$];
    logic         got_last[$];
    int           rd_idx = 0;

    logic [511:0] exp_blk[$];
    logic         exp_first[$];
    logic         exp_last[$];

    logic rand_ready  = 1'b0;
    logic force_ready = 1'b1;

    always @(negedge clk)
        bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;

    always @(posedge clk)
        if (rst_n && bus.out_valid && bus.out_ready) begin
            got_blk.push_back(bus.out_block);
            got_first.push_back(bus.out_first);
            got_last.push_back(bus.out_last);
        end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_empty = empty;
        while (!bus.in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check_eq("send_timeout", 512'(n), 512'(0));
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_empty = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] msg[$]);
        if (msg.size() == 0) send_beat(8'h00, 1'b1, 1'b1);
        for (int i = 0; i < msg.size(); i++)
            send_beat(msg[i], 1'(i == msg.size() - 1), 1'b0);
    endtask

    task automatic wait_blocks(input int cnt);
        int n = 0;
        while (got_blk.size() < rd_idx + cnt && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check_eq("blk_timeout", 512'(got_blk.size()), 512'(rd_idx + cnt));
    endtask

    task automatic expect_block(input string tag, input logic [511:0] eb, input logic ef, input logic el);
        if (rd_idx < got_blk.size()) begin
            check_eq({tag, "_blk"},   got_blk[rd_idx],         eb);
            check_eq({tag, "_first"}, 512'(got_first[rd_idx]), 512'(ef));
            check_eq({tag, "_last"},  512'(got_last[rd_idx]),  512'(el));
            rd_idx++;
        end else begin
            check_eq({tag, "_missing"}, 512'(got_blk.size()), 512'(rd_idx + 1));
        end
    endtask

    // Reference MD4 padding of a whole message
    task automatic model_push(input logic [7:0] msg[$]);
        int n    = msg.size();
        int nblk = (n + 8) / 64 + 1;
        int tot  = nblk * 64;
        logic [63:0] bits = 64'(n) * 64'd8;
        for (int b = 0; b < nblk; b++) begin
            logic [511:0] blk;
            blk = '0;
            for (int i = 0; i < 64; i++) begin
                int p;
                logic [7:0] v;
                p = b * 64 + i;
                if (p < n)              v = msg[p];
                else if (p == n)        v = 8'h80;
                else if (p >= tot - 8)  v = bits[8*(p-(tot-8)) +: 8];
                else                    v = 8'h00;
                blk[8*i +: 8] = v;
            end
            exp_blk.push_back(blk);
            exp_first.push_back(1'(b == 0));
            exp_last.push_back(1'(b == nblk - 1));
        end
    endtask

    initial begin
        logic [511:0] abc_exp;
        logic [511:0] e;
        logic [511:0] ref_blk;
        logic [7:0]   msg[$];
        int           bad;
        int           n;
        int           lens[3];

        abc_exp = (512'h18 << 448) | 512'h80636261;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        bus.in_empty = 1'b0;

        // reset values
        #12;
        check_eq("rst_out_valid", 512'(bus.out_valid), 512'(0));
        check_eq("rst_in_ready",  512'(bus.in_ready),  512'(0));
        check_eq("rst_out_block", bus.out_block,       512'(0));
        check_eq("rst_out_first", 512'(bus.out_first), 512'(0));
        check_eq("rst_out_last",  512'(bus.out_last),  512'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // zero-length message
        send_beat(8'h00, 1'b1, 1'b1);
        idle();
        wait_blocks(1);
        expect_block("empty", 512'h80, 1'b1, 1'b1);

        // "abc" with last-beat latency
        send_beat(8'h61, 1'b0, 1'b0);
        send_beat(8'h62, 1'b0, 1'b0);
        send_beat(8'h63, 1'b1, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check_eq("abc_lat_pad",  512'(bus.out_valid), 512'(0));
        @(negedge clk);
        check_eq("abc_lat_emit", 512'(bus.out_valid), 512'(1));
        wait_blocks(1);
        expect_block("abc", abc_exp, 1'b1, 1'b1);

        // 56 bytes, with a stray empty non-last beat that must be ignored
        for (int i = 0; i < 56; i++) begin
            send_beat(8'(i), 1'(i == 55), 1'b0);
            if (i == 20) send_beat(8'hAA, 1'b0, 1'b1);
        end
        idle();
        wait_blocks(2);
        e = '0;
        for (int i = 0; i < 56; i++) e[8*i +: 8] = 8'(i);
        e[8*56 +: 8] = 8'h80;
        expect_block("b56_1", e, 1'b1, 1'b0);
        expect_block("b56_2", 512'h1C0 << 448, 1'b0, 1'b1);

        // 64 bytes: full block straight to EMIT, then pad-only block
        for (int i = 0; i < 64; i++) send_beat(8'(i), 1'(i == 63), 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check_eq("b64_full_lat",  512'(bus.out_valid), 512'(1));
        check_eq("b64_full_last", 512'(bus.out_last),  512'(0));
        wait_blocks(2);
        e = '0;
        for (int i = 0; i < 64; i++) e[8*i +: 8] = 8'(i);
        expect_block("b64_1", e, 1'b1, 1'b0);
        expect_block("b64_2", (512'h200 << 448) | 512'h80, 1'b0, 1'b1);

        // backpressure: block held for 10 stalled cycles
        force_ready = 1'b0;
        @(negedge clk);
        send_beat(8'h61, 1'b0, 1'b0);
        send_beat(8'h62, 1'b0, 1'b0);
        send_beat(8'h63, 1'b1, 1'b0);
        idle();
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        ref_blk = bus.out_block;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_block !== ref_blk || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
        end
        check_eq("bp_stable", 512'(bad), 512'(0));
        check_eq("bp_block",  ref_blk,   abc_exp);
        force_ready = 1'b1;
        wait_blocks(1);
        expect_block("bp_abc", abc_exp, 1'b1, 1'b1);

        // random messages under random out_ready against the reference model
        lens[0] = 200;
        lens[1] = 63;
        lens[2] = 120;
        rand_ready = 1'b1;
        for (int m = 0; m < 3; m++) begin
            msg.delete();
            for (int i = 0; i < lens[m]; i++) msg.push_back(8'($urandom_range(0, 255)));
            model_push(msg);
            send_msg(msg);
        end
        idle();
        wait_blocks(exp_blk.size());
        rand_ready = 1'b0;
        for (int k = 0; k < exp_blk.size(); k++)
            expect_block($sformatf("rnd%0d", k), exp_blk[k], exp_first[k], exp_last[k]);

        // async reset after 30 bytes discards the partial block
        for (int i = 0; i < 30; i++) send_beat(8'(i + 1), 1'b0, 1'b0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mrst_out_block", bus.out_block,       512'(0));
        check_eq("mrst_in_ready",  512'(bus.in_ready),  512'(0));
        check_eq("mrst_out_valid", 512'(bus.out_valid), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
        send_msg(msg);
        idle();
        wait_blocks(1);
        expect_block("mrst_abc", abc_exp, 1'b1, 1'b1);

        repeat (5) @(negedge clk);
        check_eq("extra_blocks", 512'(got_blk.size()), 512'(rd_idx));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
